fwrisc_mem_responder: RTL and testbench



---
 rtl/fwrisc_mem_pkg.sv | 21 ++
 rtl/fwrisc_mem_ram.sv | 32 +++
 rtl/fwrisc_mem_responder.sv | 121 ++++++++++++
 tb/tb_fwrisc_mem_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fwrisc_mem_pkg.sv
// Shared types and helpers for the fwrisc memory responder.
package fwrisc_mem_pkg;

    // Width of the per-port wait-state counter (0..15 extra cycles).
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [2:0] {
        StIdle,
        StIWait,
        StDWait,
        StIResp,
        StDResp
    } mem_state_e;

    // Byte address to word index; callers truncate to their RAM depth,
    // so the upper address bits wrap.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/fwrisc_mem_ram.sv
// Single-port 32-bit word RAM with byte-lane write strobes and registered,
// read-before-write output. Contents are not reset.
module fwrisc_mem_ram #(
    parameter int unsigned ADDR_BITS = 10,
    parameter string       INIT_FILE = ""
) (
    input  logic                 clock,
    input  logic                 en,
    input  logic                 we,
    input  logic [3:0]           strb,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [31:0] mem [2**ADDR_BITS];

    // Read returns the word as it was before any write in the same access.
    always_ff @(posedge clock) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (strb[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fwrisc_mem_responder.sv
// Memory-side responder for the fwrisc instruction and data buses, backed by
// one shared single-port RAM with per-port programmable wait states.
module fwrisc_mem_responder
    import fwrisc_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned I_WAIT    = 0,
    parameter int unsigned D_WAIT    = 0,
    parameter string       INIT_FILE = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] iaddr,
    input  logic        ivalid,
    output logic        iready,
    output logic [31:0] idata,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dstrb,
    input  logic        dwrite,
    input  logic        dvalid,
    output logic        dready,
    output logic [31:0] drdata
);

    mem_state_e        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [31:0]       idata_hold;
    logic [31:0]       drdata_hold;

    logic              i_go;
    logic              d_go;
    logic [31:0]       acc_addr;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [31:0]       ram_rdata;

    // RAM access fires only on the last wait cycle with the request still held,
    // so an aborted or reset transaction never touches memory.
    always_comb begin
        i_go     = (state == StIWait) && ivalid && (wait_cnt == '0);
        d_go     = (state == StDWait) && dvalid && (wait_cnt == '0);
        acc_addr = (state == StDWait) ? daddr : iaddr;
        ram_addr = ADDR_BITS'(word_index(acc_addr));
    end

    fwrisc_mem_ram #(
        .ADDR_BITS (ADDR_BITS),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clock (clock),
        .en    (i_go | d_go),
        .we    (d_go & dwrite),
        .strb  (dstrb),
        .addr  (ram_addr),
        .wdata (dwdata),
        .rdata (ram_rdata)
    );

    // Arbitration, wait counting and ready pulses; data port has priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            wait_cnt    <= '0;
            iready      <= 1'b0;
            dready      <= 1'b0;
            idata_hold  <= '0;
            drdata_hold <= '0;
        end else begin
            iready <= 1'b0;
            dready <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (dvalid) begin
                        state    <= StDWait;
                        wait_cnt <= WAIT_W'(D_WAIT);
                    end else if (ivalid) begin
                        state    <= StIWait;
                        wait_cnt <= WAIT_W'(I_WAIT);
                    end
                end
                StIWait: begin
                    if (!ivalid) begin
                        state <= StIdle;
                    end else if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        state  <= StIResp;
                        iready <= 1'b1;
                    end
                end
                StDWait: begin
                    if (!dvalid) begin
                        state <= StIdle;
                    end else if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        state  <= StDResp;
                        dready <= 1'b1;
                    end
                end
                StIResp: begin
                    idata_hold <= ram_rdata;
                    state      <= StIdle;
                end
                StDResp: begin
                    drdata_hold <= ram_rdata;
                    state       <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // The RAM output register is the data source during the ready cycle;
    // the hold registers keep each port's last word afterwards.
    always_comb begin
        idata  = iready ? ram_rdata : idata_hold;
        drdata = dready ? ram_rdata : drdata_hold;
    end

endmodule

// File: tb/tb_fwrisc_mem_responder.sv
// Directed bench: instance 0 uses default wait states, instance 1 uses
// I_WAIT=1 / D_WAIT=3 for latency, abort and reset-mid-transaction cases.
module tb_fwrisc_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] iaddr  [2];
    logic        ivalid [2];
    logic        iready [2];
    logic [31:0] idata  [2];
    logic [31:0] daddr  [2];
    logic [31:0] dwdata [2];
    logic [3:0]  dstrb  [2];
    logic        dwrite [2];
    logic        dvalid [2];
    logic        dready [2];
    logic [31:0] drdata [2];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    fwrisc_mem_responder u_dut0 (
        .clock  (clock),
        .reset  (reset),
        .iaddr  (iaddr[0]),
        .ivalid (ivalid[0]),
        .iready (iready[0]),
        .idata  (idata[0]),
        .daddr  (daddr[0]),
        .dwdata (dwdata[0]),
        .dstrb  (dstrb[0]),
        .dwrite (dwrite[0]),
        .dvalid (dvalid[0]),
        .dready (dready[0]),
        .drdata (drdata[0])
    );

    fwrisc_mem_responder #(
        .I_WAIT (1),
        .D_WAIT (3)
    ) u_dut1 (
        .clock  (clock),
        .reset  (reset),
        .iaddr  (iaddr[1]),
        .ivalid (ivalid[1]),
        .iready (iready[1]),
        .idata  (idata[1]),
        .daddr  (daddr[1]),
        .dwdata (dwdata[1]),
        .dstrb  (dstrb[1]),
        .dwrite (dwrite[1]),
        .dvalid (dvalid[1]),
        .dready (dready[1]),
        .drdata (drdata[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Data access on instance u; returns read word and cycles to dready.
    task automatic data_access(input int u, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               output logic [31:0] rdata, output int lat);
        @(negedge clock);
        daddr[u]  = addr;
        dwdata[u] = wdata;
        dstrb[u]  = strb;
        dwrite[u] = wr;
        dvalid[u] = 1'b1;
        lat = 0;
        rdata = 'x;
        while (lat < 40) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (iready[u]) check("no_iready_on_data", 32'(iready[u]), 32'd0);
            if (dready[u]) break;
        end
        if (!dready[u]) check("dready_timeout", 32'(dready[u]), 32'd1);
        rdata = drdata[u];
        @(posedge clock);
        #1 dvalid[u] = 1'b0;
        @(negedge clock);
        check("dready_pulse", 32'(dready[u]), 32'd0);
    endtask

    task automatic fetch(input int u, input logic [31:0] addr,
                         output logic [31:0] word, output int lat);
        @(negedge clock);
        iaddr[u]  = addr;
        ivalid[u] = 1'b1;
        lat = 0;
        word = 'x;
        while (lat < 40) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (iready[u]) break;
        end
        if (!iready[u]) check("iready_timeout", 32'(iready[u]), 32'd1);
        word = idata[u];
        @(posedge clock);
        #1 ivalid[u] = 1'b0;
        @(negedge clock);
        check("iready_pulse", 32'(iready[u]), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        logic        seen;

        for (int u = 0; u < 2; u++) begin
            iaddr[u] = '0; ivalid[u] = 1'b0; daddr[u] = '0; dwdata[u] = '0;
            dstrb[u] = '0; dwrite[u] = 1'b0; dvalid[u] = 1'b0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_iready", 32'(iready[0]), 32'd0);
        check("rst_dready", 32'(dready[0]), 32'd0);
        check("rst_idata", idata[0], 32'd0);
        check("rst_drdata", drdata[0], 32'd0);
        check("rst_drdata_w", drdata[1], 32'd0);
        reset = 1'b0;

        // Word 0 = NOP, then fetch it with default latency.
        data_access(0, 1'b1, 32'h0, 32'h0000_0013, 4'hf, rd, lat);
        check("wr0_lat", 32'(lat), 32'd2);
        fetch(0, 32'h0, rd, lat);
        check("fetch0_data", rd, 32'h0000_0013);
        check("fetch0_lat", 32'(lat), 32'd2);
        check("idata_hold", idata[0], 32'h0000_0013);

        // Byte-lane write over a zeroed word; write returns the pre-write word.
        data_access(0, 1'b1, 32'h10, 32'h0, 4'hf, rd, lat);
        data_access(0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, rd, lat);
        check("strb_wr_old", rd, 32'h0);
        data_access(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, lat);
        check("strb_rd", rd, 32'h00BB_00DD);
        data_access(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, rd, lat);
        check("nostrb_wr_old", rd, 32'h00BB_00DD);
        data_access(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, lat);
        check("nostrb_rd", rd, 32'h00BB_00DD);

        // Simultaneous data read 0x4 and fetch 0x8: data first, fetch 3 cycles later.
        data_access(0, 1'b1, 32'h4, 32'h1111_1111, 4'hf, rd, lat);
        data_access(0, 1'b1, 32'h8, 32'h2222_2222, 4'hf, rd, lat);
        @(negedge clock);
        daddr[0] = 32'h4; dwrite[0] = 1'b0; dvalid[0] = 1'b1;
        iaddr[0] = 32'h8; ivalid[0] = 1'b1;
        lat = 0;
        while (lat < 40) begin
            @(posedge clock); lat++;
            @(negedge clock);
            if (dready[0]) break;
        end
        check("arb_d_lat", 32'(lat), 32'd2);
        check("arb_d_data", drdata[0], 32'h1111_1111);
        check("arb_i_low", 32'(iready[0]), 32'd0);
        @(posedge clock);
        #1 dvalid[0] = 1'b0;
        lat = 1;
        while (lat < 40) begin
            @(negedge clock);
            if (iready[0]) break;
            @(posedge clock); lat++;
        end
        check("arb_i_gap", 32'(lat), 32'd3);
        check("arb_i_data", idata[0], 32'h2222_2222);
        @(posedge clock);
        #1 ivalid[0] = 1'b0;

        // Address wrap with ADDR_BITS=10, low address bits ignored.
        data_access(0, 1'b1, 32'h1000, 32'h1234_5678, 4'hf, rd, lat);
        data_access(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, lat);
        check("wrap_rd0", rd, 32'h1234_5678);
        data_access(0, 1'b0, 32'h3, 32'h0, 4'h0, rd, lat);
        check("wrap_rd3", rd, 32'h1234_5678);

        // Wait-state instance.
        data_access(1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hf, rd, lat);
        check("dwait_wr_lat", 32'(lat), 32'd5);
        data_access(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, lat);
        check("dwait_rd_lat", 32'(lat), 32'd5);
        check("dwait_rd", rd, 32'hCAFE_F00D);
        fetch(1, 32'h20, rd, lat);
        check("iwait_lat", 32'(lat), 32'd3);
        check("iwait_data", rd, 32'hCAFE_F00D);

        // Abort: write dropped mid-wait must not land or pulse dready.
        @(negedge clock);
        daddr[1] = 32'h20; dwdata[1] = 32'h0; dstrb[1] = 4'hf; dwrite[1] = 1'b1;
        dvalid[1] = 1'b1;
        repeat (2) @(posedge clock);
        #1 dvalid[1] = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            seen |= dready[1];
        end
        check("abort_no_ready", 32'(seen), 32'd0);
        data_access(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, lat);
        check("abort_ram", rd, 32'hCAFE_F00D);

        // Reset during a write's wait states.
        data_access(1, 1'b1, 32'h24, 32'h5A5A_5A5A, 4'hf, rd, lat);
        @(negedge clock);
        daddr[1] = 32'h24; dwdata[1] = 32'h0; dstrb[1] = 4'hf; dwrite[1] = 1'b1;
        dvalid[1] = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        dvalid[1] = 1'b0;
        @(negedge clock);
        check("rst_mid_drdata", drdata[1], 32'd0);
        check("rst_mid_drdata0", drdata[0], 32'd0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            seen |= dready[1];
        end
        check("rst_mid_no_ready", 32'(seen), 32'd0);
        data_access(1, 1'b0, 32'h24, 32'h0, 4'h0, rd, lat);
        check("rst_mid_ram", rd, 32'h5A5A_5A5A);
        fetch(1, 32'h20, rd, lat);
        check("rst_fetch_lat", 32'(lat), 32'd3);
        check("rst_fetch_data", rd, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
